// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback block.
//   XLEN / REG_AW : datapath and register-address widths
//   ZERO_REG      : hard-wired zero register, writes to it are dropped
//   wb_entry_t    : one buffered result {rd, data}
//   gnt_e         : arbitration outcome for the single write port
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LSU} gnt_e;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of writeback entries.
//   clk, rst_n     : clock, async active-low reset (empties the FIFO)
//   push_i, din_i  : enqueue (caller guarantees !full_o)
//   pop_i          : dequeue head (caller guarantees !empty_o)
//   full_o/empty_o : occupancy flags
//   head_o         : oldest entry
//   ent_o, vld_o   : every slot in age order, index 0 = oldest, for forwarding
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  wb_entry_t       din_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output wb_entry_t       head_o,
  output wb_entry_t       ent_o [DEPTH],
  output logic [DEPTH-1:0] vld_o
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [AW:0]   cnt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign cnt     = wptr_q - rptr_q;
  assign full_o  = (cnt == (AW+1)'(DEPTH));
  assign empty_o = (cnt == '0);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Payload storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [AW-1:0] OFF = AW'(i);
    assign ent_o[i] = mem_q[rptr_q[AW-1:0] + OFF];
    assign vld_o[i] = (cnt > (AW+1)'(i));
  end
endmodule

// File: rtl/regfile_writeback.sv
// Write-side master for the register file's single write port.
//   alu_* / lsu_*   : producer valid/ready result channels, each into a FIFO
//   WriteRegNum/Data/RegWrite : registered write port (RegWrite=0 for x0)
//   fwd_rs1/2 -> fwd_hit1/2, fwd_data1/2 : youngest pending value lookup
//   busy            : any buffered entry or a write in flight
// LSU wins the port by default; the ALU wins when the LSU FIFO is empty or
// after STARVE_LIMIT consecutive losses.
module regfile_writeback #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = wb_pkg::XLEN,
  parameter int REG_AW       = wb_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic [REG_AW-1:0] WriteRegNum,
  output logic [XLEN-1:0]   WriteRegData,
  output logic              RegWrite,
  input  logic [REG_AW-1:0] fwd_rs1,
  output logic              fwd_hit1,
  output logic [XLEN-1:0]   fwd_data1,
  input  logic [REG_AW-1:0] fwd_rs2,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data2,
  output logic              busy
);
  import wb_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  wb_entry_t        alu_head, lsu_head, win;
  wb_entry_t        alu_ent [DEPTH];
  wb_entry_t        lsu_ent [DEPTH];
  logic [DEPTH-1:0] alu_vld, lsu_vld;
  logic             alu_full, alu_empty, lsu_full, lsu_empty;
  logic             alu_push, lsu_push;
  gnt_e             gnt;

  logic [SW-1:0]     starve_q, starve_d;
  logic              rw_q, rw_d;
  logic [REG_AW-1:0] num_q, num_d;
  logic [XLEN-1:0]   data_q, data_d;

  assign alu_ready = !alu_full;
  assign lsu_ready = !lsu_full;
  assign alu_push  = alu_valid && alu_ready;
  assign lsu_push  = lsu_valid && lsu_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(alu_push), .din_i('{rd: alu_rd, data: alu_data}),
    .pop_i(gnt == GNT_ALU), .full_o(alu_full), .empty_o(alu_empty),
    .head_o(alu_head), .ent_o(alu_ent), .vld_o(alu_vld)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(lsu_push), .din_i('{rd: lsu_rd, data: lsu_data}),
    .pop_i(gnt == GNT_LSU), .full_o(lsu_full), .empty_o(lsu_empty),
    .head_o(lsu_head), .ent_o(lsu_ent), .vld_o(lsu_vld)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (!alu_empty && (lsu_empty || starve_q == LIM)) gnt = GNT_ALU;
    else if (!lsu_empty)                              gnt = GNT_LSU;
  end

  // Counts ALU losses only while the ALU actually has something waiting.
  always_comb begin
    starve_d = starve_q;
    if (gnt == GNT_ALU)
      starve_d = '0;
    else if (gnt == GNT_LSU && !alu_empty && starve_q != LIM)
      starve_d = starve_q + 1'b1;
  end

  assign win = (gnt == GNT_ALU) ? alu_head : lsu_head;

  always_comb begin
    rw_d   = 1'b0;
    num_d  = num_q;
    data_d = data_q;
    if (gnt != GNT_NONE) begin
      num_d  = win.rd;
      data_d = win.data;
      rw_d   = (win.rd != ZERO_REG);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      rw_q     <= 1'b0;
      num_q    <= '0;
      data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      rw_q     <= rw_d;
      num_q    <= num_d;
      data_q   <= data_d;
    end
  end

  assign RegWrite     = rw_q;
  assign WriteRegNum  = num_q;
  assign WriteRegData = data_q;
  assign busy         = !alu_empty || !lsu_empty || rw_q;

  // Scan oldest to youngest so the last match wins: output register first,
  // then FIFO slots in age order. A given rd lives in at most one FIFO.
  logic [REG_AW-1:0] rs  [2];
  logic              hit [2];
  logic [XLEN-1:0]   fd  [2];

  assign rs[0] = fwd_rs1;
  assign rs[1] = fwd_rs2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit[p] = 1'b0;
      fd[p]  = '0;
      if (rs[p] != ZERO_REG) begin
        if (rw_q && num_q == rs[p]) begin
          hit[p] = 1'b1;
          fd[p]  = data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (alu_vld[i] && alu_ent[i].rd == rs[p]) begin
            hit[p] = 1'b1;
            fd[p]  = alu_ent[i].data;
          end
          if (lsu_vld[i] && lsu_ent[i].rd == rs[p]) begin
            hit[p] = 1'b1;
            fd[p]  = lsu_ent[i].data;
          end
        end
      end
    end
  end

  assign fwd_hit1  = hit[0];
  assign fwd_data1 = fd[0];
  assign fwd_hit2  = hit[1];
  assign fwd_data2 = fd[1];
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;
  localparam int NCYC  = 800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 0, lsu_valid = 0;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd = 0, lsu_rd = 0, fwd_rs1 = 0, fwd_rs2 = 0;
  logic [31:0] alu_data = 0, lsu_data = 0;
  logic [4:0]  WriteRegNum;
  logic [31:0] WriteRegData, fwd_data1, fwd_data2;
  logic        RegWrite, fwd_hit1, fwd_hit2, busy;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .WriteRegNum(WriteRegNum), .WriteRegData(WriteRegData), .RegWrite(RegWrite),
    .fwd_rs1(fwd_rs1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_rs2(fwd_rs2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .busy(busy)
  );

  // Reference model: two queues of pending results plus the last issued write.
  typedef struct { int rd; logic [31:0] d; } ent_t;
  ent_t        aq[$], lq[$];
  int          sc;
  logic        exp_rw;
  logic [4:0]  exp_num;
  logic [31:0] exp_data;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    aq.delete(); lq.delete();
    sc = 0; exp_rw = 0; exp_num = 0; exp_data = 0;
  endtask

  // Youngest pending value for rs; returns {hit, data}.
  function automatic logic [32:0] fwd_ref(input int rs);
    if (rs == 0) return 33'd0;
    for (int i = lq.size() - 1; i >= 0; i--) if (lq[i].rd == rs) return {1'b1, lq[i].d};
    for (int i = aq.size() - 1; i >= 0; i--) if (aq[i].rd == rs) return {1'b1, aq[i].d};
    if (exp_rw && int'(exp_num) == rs) return {1'b1, exp_data};
    return 33'd0;
  endfunction

  // One clock edge of the reference behaviour.
  task automatic model_step();
    bit   acc_a, acc_l;
    ent_t e;
    acc_a = alu_valid && (aq.size() < DEPTH);
    acc_l = lsu_valid && (lq.size() < DEPTH);
    exp_rw = 0;
    if (aq.size() > 0 && (lq.size() == 0 || sc == LIM)) begin
      e = aq.pop_front(); sc = 0;
      exp_num = 5'(e.rd); exp_data = e.d; exp_rw = (e.rd != 0);
    end else if (lq.size() > 0) begin
      e = lq.pop_front();
      if (aq.size() > 0 && sc < LIM) sc++;
      exp_num = 5'(e.rd); exp_data = e.d; exp_rw = (e.rd != 0);
    end
    if (acc_a) aq.push_back('{rd: int'(alu_rd), d: alu_data});
    if (acc_l) lq.push_back('{rd: int'(lsu_rd), d: lsu_data});
    foreach (aq[i]) foreach (lq[j])
      assert (!(aq[i].rd != 0 && aq[i].rd == lq[j].rd))
        else $error("producer contract broken: rd %0d in both FIFOs", aq[i].rd);
  endtask

  task automatic check_outputs();
    chk("RegWrite", RegWrite, exp_rw);
    chk("WriteRegNum", WriteRegNum, exp_num);
    chk("WriteRegData", WriteRegData, exp_data);
    chk("busy", busy, (aq.size() > 0 || lq.size() > 0 || exp_rw));
    chk("alu_ready", alu_ready, aq.size() < DEPTH);
    chk("lsu_ready", lsu_ready, lq.size() < DEPTH);
  endtask

  task automatic check_fwd();
    logic [32:0] r1, r2;
    r1 = fwd_ref(int'(fwd_rs1));
    r2 = fwd_ref(int'(fwd_rs2));
    chk("fwd_hit1", fwd_hit1, r1[32]);
    chk("fwd_data1", fwd_data1, r1[31:0]);
    chk("fwd_hit2", fwd_hit2, r2[32]);
    chk("fwd_data2", fwd_data2, r2[31:0]);
  endtask

  // ALU uses r1..r15 and LSU r16..r31 (x0 allowed on both) so the two FIFOs
  // never hold the same destination.
  function automatic logic [4:0] pick_alu_rd(input int mode);
    if ($urandom_range(0, 7) == 0) return 5'd0;
    if (mode == 2) return ($urandom_range(0, 3) == 0) ? 5'd8 : 5'd7;
    return 5'($urandom_range(1, 15));
  endfunction

  function automatic logic [4:0] pick_lsu_rd();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    return 5'($urandom_range(16, 31));
  endfunction

  function automatic logic [4:0] pick_rs();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 5'd0;
    if (k == 1 && aq.size() > 0) return 5'(aq[aq.size()-1].rd);
    if (k == 2 && lq.size() > 0) return 5'(lq[0].rd);
    if (k == 3 && exp_rw) return exp_num;
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int mode;
    int lsu_seq;
    model_reset();
    lsu_seq = 16;
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      mode = cyc / (NCYC / 4);  // 0 random, 1 both saturated, 2 ALU r7/r8, 3 LSU only
      @(negedge clk);
      check_outputs();

      if (cyc == 290) begin
        // Asynchronous reset while both FIFOs hold data.
        #2 rst_n = 1'b0;
        alu_valid = 0; lsu_valid = 0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
      end

      case (mode)
        0: begin
          alu_valid = ($urandom_range(0, 1) == 1);
          lsu_valid = ($urandom_range(0, 2) == 0);
        end
        1: begin alu_valid = 1; lsu_valid = 1; end
        2: begin alu_valid = ($urandom_range(0, 3) != 0); lsu_valid = 0; end
        default: begin alu_valid = 0; lsu_valid = 1; end
      endcase
      alu_rd   = pick_alu_rd(mode);
      alu_data = $urandom;
      if (mode == 3) begin
        lsu_rd = 5'(lsu_seq);
        if (lsu_ready) lsu_seq = (lsu_seq == 31) ? 16 : lsu_seq + 1;
      end else begin
        lsu_rd = pick_lsu_rd();
      end
      lsu_data = $urandom;
      fwd_rs1  = pick_rs();
      fwd_rs2  = (mode == 2) ? 5'd7 : pick_rs();
      #1;
      check_fwd();

      @(posedge clk);
      model_step();
    end

    // Drain and confirm the block goes idle.
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
    end
    chk("busy_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
